adc_ddr_rx_checker: RTL and testbench
=====================================

Name: adc_ddr_rx_checker

Overview:
- Receive-side stage directly downstream of the ADC emulator.
- Captures the 2*WIDTH DDR sample bus on both edges of the forwarded ADC clock and rebuilds the sample stream at clk rate.
- Checks each sample against a ±STEP triangle pattern, tracks pattern lock, counts errors.
- Buffers checked samples in a small FIFO behind a valid/ready output for the capture/DMA logic.

Parameters:
WIDTH, 4, width of one sample; input bus is 2*WIDTH
STEP, 1, expected absolute step between consecutive samples (mod 2^WIDTH)
LOCK_CNT, 8, consecutive good deltas required to declare lock (1..255)
FIFO_DEPTH, 4, output FIFO entries; power of 2, >=2
ERR_W, 16, error counter width

Ports:
clk  input  1  system clock, same source as the emulator clock
reset  input  1  asynchronous, active-low
lvds_in  input  2*WIDTH  DDR bus; [WIDTH-1:0] = rising-edge half, [2*WIDTH-1:WIDTH] = falling-edge half
adc_clk_in  input  1  forwarded ADC clock; may toggle at most once per clk
clr  input  1  synchronous clear of err_cnt and ovf
m_data  output  WIDTH  FIFO head sample
m_valid  output  1  FIFO non-empty
m_ready  input  1  consumer accepts m_data when m_valid&&m_ready
locked  output  1  pattern lock
err_cnt  output  ERR_W  saturating count of bad deltas while locked
ovf  output  1  sticky: sample dropped on full FIFO

Behaviour:
- Reset (asynchronous, active-low), all outputs: m_valid=0, m_data=0, locked=0, err_cnt=0, ovf=0. Internal state: FSM=HUNT, FIFO empty, prev-valid flag=0.
- Input pipe: adc_clk_in and lvds_in pass through the same 2-stage register chain (s1,s2) so they stay aligned.
- Edge detect: s3 holds the previous s2 clock value.
  - Rising edge (s2=1,s3=0): sample = s2 data[WIDTH-1:0].
  - Falling edge (s2=0,s3=1): sample = s2 data[2*WIDTH-1:WIDTH].
  - One sample per edge.
- Sample register: captured on the edge-detect cycle (cycle 2 after first s1 capture).
- FIFO write, if any: cycle 3. m_valid rises at cycle 4. Fixed latency: 4 clk from the edge that first registers the adc_clk_in transition.
- Delta check: delta = (sample - prev) mod 2^WIDTH.
  - Good if delta==STEP or delta==2^WIDTH-STEP; anything else, including 0, is bad.
  - First sample after reset, or after loss of lock, only loads prev; no check.
  - prev updates on every sample.
- FSM:
  - HUNT: locked=0. Good increments run counter; bad clears it. Run==LOCK_CNT -> LOCKED, run cleared.
  - LOCKED: locked=1. Good: stay. Bad: err_cnt+1 (saturates at all-ones), -> HUNT, prev-valid cleared.
  - locked registered; changes the cycle after the deciding sample.
- FIFO push: sample pushed iff FSM was LOCKED before that sample's check, and that check was good. Samples in HUNT, and the failing sample, are discarded.
- Full FIFO:
  - Push without pop: sample dropped, ovf<=1 (sticky).
  - Simultaneous push and pop when full: both succeed, count unchanged, no ovf.
  - Pop when empty: ignored.
  - Pointers wrap modulo FIFO_DEPTH.
- m_data: registered head; valid whenever m_valid=1; stable while m_valid&&!m_ready.
- clr: clears err_cnt and ovf next cycle; FIFO, FSM, locked unaffected.
  - clr with same-cycle error: err_cnt=0 (clr wins).
  - clr with same-cycle overflow: ovf=1 (set wins).
- adc_clk_in stuck (no edges): no samples, state holds; no timeout.

Optional Feature:
ADC_RX_STATS_EN
- Defined: adds outputs min_val[WIDTH-1:0] and max_val[WIDTH-1:0].
  - Reset to all-ones and 0.
  - Updated with every pushed sample.
  - clr restores reset values.
- Undefined: ports and logic absent; all other behaviour identical.

Test Plan:
- Emulator triangle, defaults, m_ready=1: locked=1 after 9th sample (8 good deltas); err_cnt=0; m_data follows ±1 sequence; first m_valid 4 clk after the locking edge.
- Locked, force one sample 5 where 9 expected: err_cnt=1, locked=0 next cycle, bad sample not pushed; relock after 9 further clean samples.
- m_ready=0, locked stream: FIFO fills after 4 pushes, 5th push sets ovf=1, m_data holds the first sample; m_ready=1 drains exactly 4 entries in order.
- FIFO full with m_ready=1 and push in the same cycle: no ovf, occupancy stays 4.
- Pulse clr with err_cnt=3, ovf=1: both 0 next cycle, locked unchanged. Assert reset mid-stream: all outputs 0 immediately, FIFO empty.
- ADC_RX_STATS_EN defined, one full triangle period 0..15..0: min_val=0, max_val=15; after clr: 15/0.

Source files
------------

// File: rtl/adc_ddr_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : adc_ddr_rx_checker
// Purpose  : DDR ADC capture, +/-STEP triangle check with lock tracking,
//            error counting and a small valid/ready output FIFO.
// Options  : `define ADC_RX_STATS_EN adds min_val/max_val outputs.
// Revision : 1.0 - initial release
// ============================================================================
module adc_ddr_rx_checker #(
    parameter int WIDTH      = 4,
    parameter int STEP       = 1,
    parameter int LOCK_CNT   = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 16
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [2*WIDTH-1:0] lvds_in,
    input  logic               adc_clk_in,
    input  logic               clr,
    output logic [WIDTH-1:0]   m_data,
    output logic               m_valid,
    input  logic               m_ready,
    output logic               locked,
    output logic [ERR_W-1:0]   err_cnt,
    output logic               ovf
`ifdef ADC_RX_STATS_EN
    ,
    output logic [WIDTH-1:0]   min_val,
    output logic [WIDTH-1:0]   max_val
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [WIDTH-1:0] STEP_UP = WIDTH'(STEP);
    localparam logic [WIDTH-1:0] STEP_DN = ~STEP_UP + WIDTH'(1);

    typedef enum logic [0:0] {
        S_HUNT   = 1'b0,
        S_LOCKED = 1'b1
    } state_t;

    logic               s1_clk_q, s2_clk_q, s3_clk_q;
    logic [2*WIDTH-1:0] s1_data_q, s2_data_q;
    logic [WIDTH-1:0]   sample_q, sample_d;
    logic               sample_vld_q, sample_vld_d;

    state_t             state_q;
    logic [7:0]         run_q;
    logic [WIDTH-1:0]   prev_q;
    logic               prev_vld_q;
    logic               locked_q;
    logic [ERR_W-1:0]   err_cnt_q;

    logic [WIDTH-1:0]   delta;
    logic               good;
    logic               push;

    logic [WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d, avail;
    logic               full, pop, wr_en;
    logic               ovf_q, ovf_d;
    logic               m_valid_q, m_valid_d;
    logic [WIDTH-1:0]   m_data_q, m_data_d;

    // Clock and data share one synchroniser chain so each edge sees its own data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_clk_q  <= 1'b0;
            s2_clk_q  <= 1'b0;
            s3_clk_q  <= 1'b0;
            s1_data_q <= '0;
            s2_data_q <= '0;
        end else begin
            s1_clk_q  <= adc_clk_in;
            s2_clk_q  <= s1_clk_q;
            s3_clk_q  <= s2_clk_q;
            s1_data_q <= lvds_in;
            s2_data_q <= s1_data_q;
        end
    end

    always_comb begin
        sample_vld_d = s2_clk_q ^ s3_clk_q;
        sample_d     = sample_q;
        if (s2_clk_q && !s3_clk_q) begin
            sample_d = s2_data_q[WIDTH-1:0];
        end else if (!s2_clk_q && s3_clk_q) begin
            sample_d = s2_data_q[2*WIDTH-1:WIDTH];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sample_q     <= '0;
            sample_vld_q <= 1'b0;
        end else begin
            sample_q     <= sample_d;
            sample_vld_q <= sample_vld_d;
        end
    end

    always_comb begin
        delta = sample_q - prev_q;
        good  = (delta == STEP_UP) || (delta == STEP_DN);
        push  = sample_vld_q && prev_vld_q && good && (state_q == S_LOCKED);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_HUNT;
            run_q      <= '0;
            prev_q     <= '0;
            prev_vld_q <= 1'b0;
            locked_q   <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            if (clr) begin
                err_cnt_q <= '0;
            end
            if (sample_vld_q) begin
                prev_q     <= sample_q;
                prev_vld_q <= 1'b1;
                if (prev_vld_q) begin
                    case (state_q)
                        S_HUNT: begin
                            if (!good) begin
                                run_q <= '0;
                            end else if (run_q == 8'(LOCK_CNT - 1)) begin
                                state_q  <= S_LOCKED;
                                locked_q <= 1'b1;
                                run_q    <= '0;
                            end else begin
                                run_q <= run_q + 8'd1;
                            end
                        end
                        S_LOCKED: begin
                            if (!good) begin
                                state_q    <= S_HUNT;
                                locked_q   <= 1'b0;
                                prev_vld_q <= 1'b0;
                                if (!clr && (err_cnt_q != '1)) begin
                                    err_cnt_q <= err_cnt_q + ERR_W'(1);
                                end
                            end
                        end
                        default: state_q <= S_HUNT;
                    endcase
                end
            end
        end
    end

    // Output register is refilled from post-pop state, so it never lags a pop.
    always_comb begin
        pop      = m_valid_q && m_ready;
        full     = (count_q == CNT_W'(FIFO_DEPTH));
        wr_en    = push && (!full || pop);
        count_d  = count_q;
        if (wr_en && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!wr_en && pop) begin
            count_d = count_q - CNT_W'(1);
        end
        wr_ptr_d = wr_en ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop   ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        ovf_d    = clr ? 1'b0 : ovf_q;
        if (push && full && !pop) begin
            ovf_d = 1'b1;
        end
        avail     = pop ? count_q - CNT_W'(1) : count_q;
        m_valid_d = (avail != '0);
        m_data_d  = m_valid_d ? mem_q[rd_ptr_d] : m_data_q;
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_ptr_q] <= sample_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            ovf_q     <= ovf_d;
            m_valid_q <= m_valid_d;
            m_data_q  <= m_data_d;
        end
    end

    assign m_data  = m_data_q;
    assign m_valid = m_valid_q;
    assign locked  = locked_q;
    assign err_cnt = err_cnt_q;
    assign ovf     = ovf_q;

`ifdef ADC_RX_STATS_EN
    logic [WIDTH-1:0] min_q, min_d, max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        if (clr) begin
            min_d = '1;
            max_d = '0;
        end else if (push) begin
            if (sample_q < min_q) min_d = sample_q;
            if (sample_q > max_q) max_d = sample_q;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            min_q <= '1;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_val = min_q;
    assign max_val = max_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_adc_ddr_rx_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_adc_ddr_rx_checker
// Purpose  : Directed scoreboard bench for adc_ddr_rx_checker (default params).
// Revision : 1.0 - initial release
// ============================================================================
module tb_adc_ddr_rx_checker;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        adc_clk_in = 1'b0;
    logic        clr = 1'b0;
    logic        m_ready = 1'b1;
    logic [7:0]  lvds_in = 8'h00;
    logic [3:0]  m_data;
    logic        m_valid;
    logic        locked;
    logic        ovf;
    logic [15:0] err_cnt;
`ifdef ADC_RX_STATS_EN
    logic [3:0]  min_val, max_val;
`endif

    int         checks = 0;
    int         errors = 0;
    int         n_pop  = 0;
    int         idx    = 0;
    int         n0;
    logic [3:0] exp_q[$];
    logic [3:0] e;
    logic       lat [5];

    adc_ddr_rx_checker dut (
        .clk        (clk),
        .reset      (reset),
        .lvds_in    (lvds_in),
        .adc_clk_in (adc_clk_in),
        .clr        (clr),
        .m_data     (m_data),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .locked     (locked),
        .err_cnt    (err_cnt),
        .ovf        (ovf)
`ifdef ADC_RX_STATS_EN
        ,
        .min_val    (min_val),
        .max_val    (max_val)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [3:0] tri_val(input int i);
        int m;
        m = i % 30;
        return (m < 15) ? 4'(m) : 4'(30 - m);
    endfunction

    // One adc_clk_in toggle; the active half carries v, the idle half its complement.
    task automatic drive(input logic [3:0] v);
        @(negedge clk);
        adc_clk_in = ~adc_clk_in;
        lvds_in    = adc_clk_in ? {~v, v} : {v, ~v};
    endtask

    task automatic send(input logic [3:0] v, input bit pushed);
        if (pushed) exp_q.push_back(v);
        drive(v);
        @(negedge clk);
    endtask

    task automatic send_tri(input bit pushed);
        send(tri_val(idx), pushed);
        idx++;
    endtask

    task automatic settle();
        repeat (6) @(negedge clk);
    endtask

    task automatic pulse_clr();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (m_valid && m_ready) begin
                n_pop++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h expected none", m_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("m_data", {28'd0, m_data}, {28'd0, e});
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        #1 reset = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_data", m_data, 0);
        chk("rst_locked", locked, 0);
        chk("rst_err_cnt", err_cnt, 0);
        chk("rst_ovf", ovf, 0);
`ifdef ADC_RX_STATS_EN
        chk("rst_min", min_val, 15);
        chk("rst_max", max_val, 0);
`endif
        reset = 1'b1;
        @(negedge clk);

        // Acquire lock: 8 samples are not enough, the 9th locks.
        for (int i = 0; i < 8; i++) send_tri(0);
        settle();
        chk("locked_after_8", locked, 0);
        send_tri(0);
        settle();
        chk("locked_after_9", locked, 1);

        // First pushed sample: m_valid rises on the 4th edge after capture.
        exp_q.push_back(tri_val(idx));
        drive(tri_val(idx));
        idx++;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            lat[k] = m_valid;
        end
        for (int k = 0; k < 5; k++) chk($sformatf("valid_latency_e%0d", k), lat[k], (k == 4) ? 1 : 0);
        for (int i = 0; i < 10; i++) send_tri(1);
        settle();
        chk("stream_err_cnt", err_cnt, 0);
        chk("stream_ovf", ovf, 0);
        chk("stream_drained", exp_q.size(), 0);

        // One bad sample (5 where 9 expected) while locked.
        send_tri(1);
        send(4'd5, 0);
        idx++;
        settle();
        chk("bad_err_cnt", err_cnt, 1);
        chk("bad_unlocked", locked, 0);
        for (int i = 0; i < 8; i++) send_tri(0);
        settle();
        chk("relock_after_8", locked, 0);
        send_tri(0);
        settle();
        chk("relock_after_9", locked, 1);
        send_tri(1);
        settle();

        // Fill the FIFO with the consumer stalled, then overflow it.
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) send_tri(1);
        settle();
        chk("full_no_ovf", ovf, 0);
        chk("full_m_valid", m_valid, 1);
        send_tri(0);
        settle();
        chk("overflow_ovf", ovf, 1);
        chk("head_hold", m_data, 2);
        pulse_clr();
        chk("clr1_ovf", ovf, 0);
        chk("clr1_err_cnt", err_cnt, 0);
        chk("clr1_locked", locked, 1);
        chk("clr1_m_valid", m_valid, 1);

        // Full FIFO: pop and push land on the same edge.
        exp_q.push_back(tri_val(idx));
        drive(tri_val(idx));
        idx++;
        repeat (3) @(negedge clk);
        m_ready = 1'b1;
        @(negedge clk);
        m_ready = 1'b0;
        chk("swap_no_ovf", ovf, 0);
        chk("swap_head", m_data, 3);
        send_tri(0);
        settle();
        chk("swap_still_full", ovf, 1);
        pulse_clr();
        m_ready = 1'b1;
        n0 = n_pop;
        settle();
        chk("drain_count", n_pop - n0, 4);
        chk("drain_queue", exp_q.size(), 0);
        chk("drain_m_valid", m_valid, 0);

        // Three errors, each followed by a clean relock.
        for (int r = 0; r < 3; r++) begin
            send(tri_val(idx - 1), 0);
            for (int i = 0; i < 9; i++) send_tri(0);
        end
        settle();
        chk("err3_err_cnt", err_cnt, 3);
        chk("err3_locked", locked, 1);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) send_tri(i < 4);
        settle();
        chk("err3_ovf", ovf, 1);
        pulse_clr();
        chk("clr2_err_cnt", err_cnt, 0);
        chk("clr2_ovf", ovf, 0);
        chk("clr2_locked", locked, 1);
        chk("clr2_m_valid", m_valid, 1);

        // Asynchronous reset mid-stream with a full FIFO.
        @(negedge clk);
        #2 reset = 1'b0;
        adc_clk_in = 1'b0;
        lvds_in    = 8'h00;
        #1;
        chk("mid_rst_m_valid", m_valid, 0);
        chk("mid_rst_m_data", m_data, 0);
        chk("mid_rst_locked", locked, 0);
        chk("mid_rst_err_cnt", err_cnt, 0);
        chk("mid_rst_ovf", ovf, 0);
        exp_q.delete();
        @(negedge clk);
        reset   = 1'b1;
        m_ready = 1'b1;
        settle();
        chk("post_rst_empty", m_valid, 0);

`ifdef ADC_RX_STATS_EN
        idx = 0;
        for (int i = 0; i < 9; i++) send_tri(0);
        for (int i = 0; i < 30; i++) send_tri(1);
        settle();
        chk("stats_min", min_val, 0);
        chk("stats_max", max_val, 15);
        pulse_clr();
        chk("stats_clr_min", min_val, 15);
        chk("stats_clr_max", max_val, 0);
`endif

        settle();
        chk("final_queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
